// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU between NREQ requesters
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         per-requester handshake (ready one-hot, IDLE only)
//   req_a/req_b/req_ci/req_f    packed per-requester operands and function code
//   alu_a/alu_b/alu_ci/alu_f    ALU drive, nonzero only in ISSUE
//   alu_s/alu_co                ALU result
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_s/rsp_co/rsp_err response payload
module alu_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int FW    = 5,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    input  logic [NREQ*FW-1:0]    req_f,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic                  alu_ci,
    output logic [FW-1:0]         alu_f,
    input  logic [WIDTH-1:0]      alu_s,
    input  logic                  alu_co,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_s,
    output logic                  rsp_co,
    output logic                  rsp_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
    state_t           r_state;
    logic [IDW-1:0]   r_last, r_id, w_gnt, w_idx;
    logic             w_any, w_code_ok, r_ci, r_co, r_err;
    logic [WIDTH-1:0] r_a, r_b, r_s, w_a, w_b;
    logic [FW-1:0]    r_f, w_f;

    // Scan downward so the candidate nearest to last+1 is the final (winning) assignment.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    assign w_a       = req_a[int'(w_gnt)*WIDTH +: WIDTH];
    assign w_b       = req_b[int'(w_gnt)*WIDTH +: WIDTH];
    assign w_f       = req_f[int'(w_gnt)*FW +: FW];
    assign w_code_ok = (w_f != '0) && (w_f <= FW'(22));
    // rst_n gating keeps req_ready low while reset is held, since IDLE is the reset state.
    assign req_ready = (rst_n && r_state == IDLE && w_any) ? NREQ'(1) << w_gnt : '0;
    assign alu_a     = (r_state == ISSUE) ? r_a : '0;
    assign alu_b     = (r_state == ISSUE) ? r_b : '0;
    assign alu_ci    = (r_state == ISSUE) ? r_ci : 1'b0;
    assign alu_f     = (r_state == ISSUE) ? r_f : '0;
    assign rsp_valid = (r_state == RESPOND);
    assign rsp_id    = r_id;
    assign rsp_s     = r_s;
    assign rsp_co    = r_co;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= IDW'(NREQ - 1);
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_f     <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_ci   <= req_ci[w_gnt];
                    r_f    <= w_f;
                    r_id   <= w_gnt;
                    r_last <= w_gnt;
                    if (w_code_ok) begin
                        r_state <= ISSUE;
                    end else begin
                        r_state <= RESPOND;
                        r_s     <= '0;
                        r_co    <= 1'b0;
                        r_err   <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_s     <= alu_s;
                    r_co    <= alu_co;
                    r_err   <= 1'b0;
                    r_state <= RESPOND;
                end
                RESPOND: if (rsp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed vectors and handshake sequences for alu_sched
module tb_alu_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0, req_ready, req_ci = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [19:0] req_f = '0;
    logic [7:0]  alu_a, alu_b, alu_s, rsp_s;
    logic        alu_ci, alu_co, rsp_valid, rsp_co, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [4:0]  alu_f;
    logic [1:0]  rsp_id;
    int          n_vec = 0, n_err = 0;

    typedef struct {
        int         rq;
        logic [7:0] a, b;
        logic       ci;
        logic [4:0] f;
        logic [7:0] s;
        logic       co, err;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    // Reference ALU: 2 = add with carry, 9 = xor, anything else = and.
    assign {alu_co, alu_s} = (alu_f == 5'd2) ? 9'(alu_a) + 9'(alu_b) + 9'(alu_ci) :
                             (alu_f == 5'd9) ? {1'b0, alu_a ^ alu_b} : {1'b0, alu_a & alu_b};

    alu_sched #(.NREQ(4), .WIDTH(8), .FW(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_f(req_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_f(alu_f),
        .alu_s(alu_s), .alu_co(alu_co), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_co(rsp_co), .rsp_err(rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int rq, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [4:0] f);
        req_valid          = '0;
        req_valid[rq]      = 1'b1;
        req_a[rq*8 +: 8]   = a;
        req_b[rq*8 +: 8]   = b;
        req_ci[rq]         = ci;
        req_f[rq*5 +: 5]   = f;
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        drive(v.rq, v.a, v.b, v.ci, v.f);
        rsp_ready = 1'b1;
        #1 chk("accept_ready", 32'(req_ready), 32'(4'b0001 << v.rq));
        @(negedge clk);
        req_valid = '0;
        #1;
        if (!v.err) begin
            chk("issue_alu_f", 32'(alu_f), 32'(v.f));
            chk("issue_alu_a", 32'(alu_a), 32'(v.a));
            chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(v.rq));
        chk("rsp_s", 32'(rsp_s), 32'(v.s));
        chk("rsp_co", 32'(rsp_co), 32'(v.co));
        chk("rsp_err", 32'(rsp_err), 32'(v.err));
        chk("rsp_alu_f_idle", 32'(alu_f), 32'd0);
        chk("rsp_no_ready", 32'(req_ready), 32'd0);
    endtask

    int g_id[$];
    int g_cyc[$];

    initial begin
        vecs[0] = '{0, 8'h05, 8'h03, 1'b0, 5'd2,  8'h08, 1'b0, 1'b0};
        vecs[1] = '{1, 8'hFF, 8'h01, 1'b0, 5'd2,  8'h00, 1'b1, 1'b0};
        vecs[2] = '{2, 8'hF0, 8'h3C, 1'b0, 5'd9,  8'hCC, 1'b0, 1'b0};
        vecs[3] = '{3, 8'h80, 8'h80, 1'b1, 5'd2,  8'h01, 1'b1, 1'b0};
        vecs[4] = '{1, 8'h12, 8'h34, 1'b1, 5'd0,  8'h00, 1'b0, 1'b1};
        vecs[5] = '{1, 8'h56, 8'h78, 1'b0, 5'd23, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{0, 8'hFF, 8'hFF, 1'b1, 5'd31, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{2, 8'hF0, 8'h3C, 1'b0, 5'd22, 8'h30, 1'b0, 1'b0};
        vecs[8] = '{3, 8'hAA, 8'h0F, 1'b0, 5'd1,  8'h0A, 1'b0, 1'b0};

        req_valid = 4'b1111;
        req_f = {4{5'd2}};
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_f", 32'(alu_f), 32'd0);
        chk("rst_rsp_s", 32'(rsp_s), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        // Round-robin from reset with all requesters continuously valid.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_f = {4{5'd2}};
        req_valid = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (req_ready != 0 && g_id.size() < 5)
                for (int j = 0; j < 4; j++) if (req_ready[j]) begin
                    g_id.push_back(j);
                    g_cyc.push_back(i);
                end
        end
        chk("rr_count", 32'(g_id.size()), 32'd5);
        for (int k = 0; k < 5; k++) if (k < g_id.size()) begin
            chk("rr_order", 32'(g_id[k]), 32'(k % 4));
            if (k > 0) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Backpressure on req2's xor result.
        drive(2, 8'hF0, 8'h3C, 1'b0, 5'd9);
        rsp_ready = 1'b0;
        #1 chk("bp_accept", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        #1 chk("bp_issue_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_s", 32'(rsp_s), 32'hCC);
            chk("bp_rsp_id", 32'(rsp_id), 32'd2);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_ready_respond", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(negedge clk);
        #1 chk("bp_withdraw_idle", 32'(alu_f), 32'd0);

        // Withdrawn request from req1 while busy.
        @(negedge clk);
        drive(0, 8'h01, 8'h01, 1'b0, 5'd2);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0010;
        #1 chk("wd_respond_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("wd_no_grant", 32'(req_ready), 32'd0);
            chk("wd_alu_idle", 32'(alu_f), 32'd0);
        end

        // Reset during ISSUE.
        @(negedge clk);
        drive(0, 8'h11, 8'h22, 1'b0, 5'd2);
        @(negedge clk);
        req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        chk("mr_alu_f", 32'(alu_f), 32'd0);
        chk("mr_alu_a", 32'(alu_a), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_rsp_s", 32'(rsp_s), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mr_first_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b1000;
        #1 chk("mr_issue", 32'(alu_f), 32'd2);
        @(negedge clk);
        #1;
        chk("mr_rsp_id", 32'(rsp_id), 32'd0);
        chk("mr_rsp_sum", 32'(rsp_s), 32'h33);
        @(negedge clk);
        #1 chk("mr_second_grant", 32'(req_ready), 32'b1000);
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one 8-bit `alu` instance between `NREQ` requesters. It accepts one operation at a time through per-requester valid/ready handshakes and registers the operands and function code. It then drives the ALU for one issue cycle, captures the result, and returns it on a single response channel tagged with the requester id. It sits between the instruction-issue logic and the shared ALU datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand/result width; must equal the ALU data width.
- `FW`, 5: function-code width; must equal the ALU function width.
- `IDW`, `$clog2(NREQ)`: width of the requester id.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NREQ  per-requester operation request.
- `req_ready`  out  NREQ  per-requester accept strobe; at most one bit high at a time.
- `req_a`  in  NREQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand b, packed the same way.
- `req_ci`  in  NREQ  carry-in.
- `req_f`  in  NREQ*FW  function code; requester i uses slice [i*FW +: FW].
- `alu_a`, `alu_b`  out  WIDTH  ALU operands.
- `alu_ci`  out  1  ALU carry-in.
- `alu_f`  out  FW  ALU function code.
- `alu_s`  in  WIDTH  ALU result.
- `alu_co`  in  1  ALU carry-out.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that issued the operation.
- `rsp_s`  out  WIDTH  result.
- `rsp_co`  out  1  carry-out.
- `rsp_err`  out  1  function code unsupported; `rsp_s`/`rsp_co` are 0.

## Operation
- The FSM has three states: IDLE, ISSUE, RESPOND. Reset enters IDLE.
- **IDLE**
  - Grant goes to the first requester with `req_valid` set, searching from `last+1` upward and wrapping modulo NREQ.
  - `req_ready[g]` is driven combinationally in the same cycle.
  - On that clock edge, the block latches `a`, `b`, `ci`, `f` and `g`, and sets `last <= g`.
  - If no `req_valid` bit is set, it stays in IDLE with all `req_ready` low.
- **Function code check**
  - Valid codes are 1..22.
  - Valid code: next state is ISSUE.
  - Code 0 or code >22: next state is RESPOND with `rsp_err`=1, `rsp_s`=0, `rsp_co`=0. The ALU is not driven.
- **ISSUE** (exactly one cycle)
  - `alu_a`/`alu_b`/`alu_ci`/`alu_f` carry the latched values.
  - At the end of the cycle, `rsp_s <= alu_s`, `rsp_co <= alu_co`, `rsp_err <= 0`, and the state moves to RESPOND.
- **Outside ISSUE**: `alu_f` is 0 (ALU holds its output); `alu_a`, `alu_b`, `alu_ci` are 0.
- **RESPOND**
  - `rsp_valid` is 1.
  - `rsp_id`, `rsp_s`, `rsp_co` and `rsp_err` stay stable until `rsp_ready` is sampled high; the block then returns to IDLE.
  - All `req_ready` bits are low in ISSUE and RESPOND.
- **Stateful codes**: 1, 18 and 19 operate on the ALU's held output. The block passes them through unchanged. Their result depends on the previous ALU operation, by design.
- **Reset values**: state IDLE, `last` = NREQ-1 (requester 0 has first priority), and every output 0.

## Timing
- Accept in cycle T means `req_valid[g]` and `req_ready[g]` are both high in T.
  - Valid code: ISSUE in T+1, `rsp_valid` high from T+2.
  - Error code: `rsp_valid` high from T+1.
- The earliest next accept is the cycle after the response handshake. Peak throughput is one operation per 3 cycles.
- A requester may drop `req_valid` at any time before acceptance; no grant is issued for it.
- A requester that holds `req_valid` after acceptance is a new request and is eligible again in the next IDLE.
- Several simultaneous valids: exactly one grant, in round-robin order. No requester waits more than NREQ-1 grants while continuously valid.
- Asserting `rst_n` low at any point, including ISSUE or RESPOND, aborts the operation immediately. The response is discarded and the reset values apply asynchronously.
- `rsp_ready` high outside RESPOND is ignored.

## Test plan
- **Single add**: req0 valid with a=8'h05, b=8'h03, f=2.
  - `req_ready[0]` in T, `alu_f`=2 in T+1.
  - `rsp_valid` in T+2 with `rsp_id`=0, `rsp_s`=8'h08, `rsp_err`=0.
- **Round-robin**: all four requesters valid continuously, `rsp_ready`=1.
  - Grant order is 0,1,2,3,0.
  - Grants are spaced 3 cycles apart.
- **Backpressure**: req2 with f=9, a=8'hF0, b=8'h3C, and `rsp_ready`=0 for 5 cycles.
  - `rsp_valid` and `rsp_s`=8'hCC are held stable.
  - No `req_ready` is asserted until `rsp_ready` goes high; the block is IDLE on the next cycle.
- **Bad code**: req1 with f=0, then f=23.
  - Each returns `rsp_valid` in T+1 with `rsp_err`=1 and `rsp_s`=0.
  - `alu_f` never leaves 0.
- **Reset mid-op**: `rst_n` pulled low during ISSUE.
  - All outputs are 0 immediately.
  - After release, a pending req3 and req0 are granted req0 first.
- **Withdrawn request**: req1 valid for 1 cycle while in RESPOND, then dropped.
  - No grant is ever issued to req1.
